odu_chk_sched: RTL and testbench
================================

ODU_CHK_SCHED -- requirements
Module: odu_chk_sched

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting ODU channels.
REQ-002 Parameter BURST_LEN, default 16, maximum data words forwarded per grant.
REQ-003 Parameter CNT_W, default 16, per-channel error counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_valid  input  NUM_CH  per-channel word valid.
REQ-007 i_data  input  NUM_CH*384  per-channel data word; channel k in bits [384k+383:384k].
REQ-008 i_fs, i_rs  input  NUM_CH each  per-channel frame start / row start flags.
REQ-009 i_mfas  input  NUM_CH*8  per-channel MFAS; channel k in bits [8k+7:8k].
REQ-010 o_ready  output  NUM_CH  per-channel accept; a word transfers when i_valid[k]&o_ready[k].
REQ-011 o_data/o_valid/o_fs/o_rs/o_mfas  output  384/1/1/1/8  registered word to shared test-data checker.
REQ-012 o_chk_rst  output  1  active-high synchronous reset pulse to the shared checker.
REQ-013 i_fr_error  input  1  checker frame-error level.
REQ-014 o_chid  output  log2(NUM_CH)  channel currently granted.
REQ-015 i_cnt_sel  input  log2(NUM_CH)  counter readout select; i_cnt_clr  input  1  clear pulse for selected channel.
REQ-016 o_err_cnt  output  CNT_W  error count of i_cnt_sel channel (combinational read); o_err_sticky  output  NUM_CH  per-channel sticky error.

Function
REQ-017 FSM states SHALL be IDLE, FLUSH, GRANT.
REQ-018 IDLE: o_ready=0; if any i_valid set, the SHALL pick the first requester after the last-granted channel (round-robin, wrapping NUM_CH-1 -> 0), latch it into o_chid, go FLUSH.
REQ-019 FLUSH: exactly one cycle, o_chk_rst=1, o_valid=0, all o_ready=0; next state GRANT.
REQ-020 GRANT: o_ready[o_chid]=1, all other o_ready=0; each transfer increments a beat counter.
REQ-021 GRANT exits to IDLE after the BURST_LEN-th transfer or in the first cycle i_valid[o_chid]=0; a final-beat transfer SHALL complete before exit.
REQ-022 o_data/o_fs/o_rs/o_mfas/o_valid SHALL be the transferred word registered, latency 1 cycle; o_valid=0 otherwise.
REQ-023 Minimum grant-to-grant gap SHALL be 2 cycles (IDLE + FLUSH), including re-grant of the same channel.
REQ-024 A sampled flag SHALL be set the cycle after each o_valid=1; in that cycle, if i_fr_error=1, the counter of the channel owning that beat increments and its sticky bit sets.
REQ-025 Counters SHALL saturate at 2^CNT_W-1.
REQ-026 i_cnt_clr SHALL zero the selected counter and sticky bit; on simultaneous clear and increment of the same channel, clear wins.
REQ-027 Grant priority pointer SHALL advance only when a channel is granted, never on idle cycles.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, o_ready=0, o_valid=0, o_fs=0, o_rs=0, o_data=0, o_mfas=0, o_chk_rst=0, o_chid=0, all counters and sticky bits 0, last-granted pointer NUM_CH-1 (channel 0 first).
REQ-029 Reset asserted mid-burst SHALL drop the burst; no partial word is emitted after deassertion.
REQ-030 First grant after reset SHALL still pass through FLUSH.

Structure
REQ-031 Shared package odu_chk_pkg SHALL hold DATA_W=384, MFAS_W=8, default NUM_CH, BURST_LEN, CNT_W and the FSM state encoding.
REQ-032 Round-robin selection SHALL be one sub-module, odu_rr_arbiter (request vector + last pointer in, one-hot/index out, combinational).
REQ-033 Total RTL SHALL be 120-400 lines.

Verification
REQ-034 Ch0 only, 20 continuous valid words -> FLUSH pulse, 16 words forwarded with o_chid=0, IDLE, FLUSH, remaining 4 words.
REQ-035 Ch0..ch3 all continuously valid -> grant order 0,1,2,3,0; each 16 words; o_chk_rst high once per grant.
REQ-036 Ch2 valid 5 words then drops -> grant ends after 5 transfers; o_ready[2] low next cycle.
REQ-037 Checker forced i_fr_error=1 during ch1 beats 3..5 -> counter1=3, sticky[1]=1, others 0.
REQ-038 Counter1 at 0xFFFE, three error beats -> reads 0xFFFF; i_cnt_clr with i_cnt_sel=1 in increment cycle -> reads 0.
REQ-039 rst_n low at beat 7 of ch3 burst -> all outputs zero immediately; after release ch0 granted first via FLUSH.

Source files
------------

// File: rtl/odu_chk_pkg.sv
// Shared constants and FSM encoding for the ODU test-data checker scheduler.
// The scheduler time-shares one checker between several ODU channels.
package odu_chk_pkg;

    localparam int DATA_W        = 384;
    localparam int MFAS_W        = 8;
    localparam int NUM_CH_DEF    = 4;
    localparam int BURST_LEN_DEF = 16;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_GRANT = 2'd2
    } sched_state_t;

    // Index width that stays legal for a single-channel build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/odu_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after i_last,
// wrapping NUM_CH-1 -> 0.
module odu_rr_arbiter
    import odu_chk_pkg::*;
#(
    parameter int  NUM_CH = NUM_CH_DEF,
    localparam int IDX_W  = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic              o_any,
    output logic [NUM_CH-1:0] o_grant_oh,
    output logic [IDX_W-1:0]  o_grant_idx
);

    logic [IDX_W:0]    w_sum      [NUM_CH];
    logic [IDX_W-1:0]  w_cand     [NUM_CH];
    logic [NUM_CH-1:0] w_cand_req;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH:0]   w_prior;
    logic [NUM_CH-1:0] w_oh_part  [NUM_CH+1];
    logic [IDX_W-1:0]  w_idx_part [NUM_CH+1];

    assign w_prior[0]    = 1'b0;
    assign w_oh_part[0]  = '0;
    assign w_idx_part[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_scan
            // Candidate gi is (i_last + 1 + gi) mod NUM_CH; one subtraction suffices.
            assign w_sum[gi]  = {1'b0, i_last} + (IDX_W+1)'(gi + 1);
            assign w_cand[gi] = (w_sum[gi] >= (IDX_W+1)'(NUM_CH))
                              ? IDX_W'(w_sum[gi] - (IDX_W+1)'(NUM_CH))
                              : IDX_W'(w_sum[gi]);
            assign w_cand_req[gi]    = i_req[w_cand[gi]];
            assign w_hit[gi]         = w_cand_req[gi] & ~w_prior[gi];
            assign w_prior[gi+1]     = w_prior[gi] | w_cand_req[gi];
            assign w_oh_part[gi+1]   = w_oh_part[gi]
                                     | (w_hit[gi] ? (NUM_CH'(1) << w_cand[gi]) : '0);
            assign w_idx_part[gi+1]  = w_idx_part[gi] | (w_hit[gi] ? w_cand[gi] : '0);
        end
    endgenerate

    assign o_any       = w_prior[NUM_CH];
    assign o_grant_oh  = w_oh_part[NUM_CH];
    assign o_grant_idx = w_idx_part[NUM_CH];

endmodule

// File: rtl/odu_chk_sched.sv
// Grants the shared test-data checker to one ODU channel at a time, resets the
// checker before every grant and keeps per-channel frame-error counters.
module odu_chk_sched
    import odu_chk_pkg::*;
#(
    parameter int  NUM_CH    = NUM_CH_DEF,
    parameter int  BURST_LEN = BURST_LEN_DEF,
    parameter int  CNT_W     = CNT_W_DEF,
    localparam int IDX_W     = idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        i_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0]        i_fs,
    input  logic [NUM_CH-1:0]        i_rs,
    input  logic [NUM_CH*MFAS_W-1:0] i_mfas,
    output logic [NUM_CH-1:0]        o_ready,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    output logic                     o_fs,
    output logic                     o_rs,
    output logic [MFAS_W-1:0]        o_mfas,
    output logic                     o_chk_rst,
    input  logic                     i_fr_error,
    output logic [IDX_W-1:0]         o_chid,
    input  logic [IDX_W-1:0]         i_cnt_sel,
    input  logic                     i_cnt_clr,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic [NUM_CH-1:0]        o_err_sticky
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    sched_state_t      r_state;
    logic [IDX_W-1:0]  r_chid;
    logic [IDX_W-1:0]  r_last;
    logic [NUM_CH-1:0] r_sel_oh;
    logic [NUM_CH-1:0] r_ready;
    logic              r_chk_rst;
    logic [BEAT_W-1:0] r_beat;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_fs;
    logic              r_rs;
    logic [MFAS_W-1:0] r_mfas;
    logic [IDX_W-1:0]  r_out_ch;
    logic              r_sampled;
    logic [IDX_W-1:0]  r_samp_ch;

    logic              w_any;
    logic [NUM_CH-1:0] w_grant_oh;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_err_inc;
    logic [DATA_W-1:0] w_ch_data [NUM_CH];
    logic [MFAS_W-1:0] w_ch_mfas [NUM_CH];
    logic [CNT_W-1:0]  w_cnt     [NUM_CH];

    odu_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req       (i_valid),
        .i_last      (r_last),
        .o_any       (w_any),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slice
            assign w_ch_data[gi] = i_data[gi*DATA_W +: DATA_W];
            assign w_ch_mfas[gi] = i_mfas[gi*MFAS_W +: MFAS_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_chid    <= '0;
            r_last    <= IDX_W'(NUM_CH - 1);
            r_sel_oh  <= '0;
            r_ready   <= '0;
            r_chk_rst <= 1'b0;
            r_beat    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_fs      <= 1'b0;
            r_rs      <= 1'b0;
            r_mfas    <= '0;
            r_out_ch  <= '0;
        end else begin
            r_valid   <= 1'b0;
            r_chk_rst <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_chid    <= w_grant_idx;
                        r_last    <= w_grant_idx;
                        r_sel_oh  <= w_grant_oh;
                        r_chk_rst <= 1'b1;
                        r_state   <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_ready <= r_sel_oh;
                    r_beat  <= '0;
                    r_state <= ST_GRANT;
                end
                ST_GRANT: begin
                    // o_ready is high on the granted channel, so valid implies a transfer.
                    if (i_valid[r_chid]) begin
                        r_valid  <= 1'b1;
                        r_data   <= w_ch_data[r_chid];
                        r_fs     <= i_fs[r_chid];
                        r_rs     <= i_rs[r_chid];
                        r_mfas   <= w_ch_mfas[r_chid];
                        r_out_ch <= r_chid;
                        r_beat   <= r_beat + 1'b1;
                        if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
                            r_ready <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_ready <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ready <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The checker reports on a word one cycle after it sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sampled <= 1'b0;
            r_samp_ch <= '0;
        end else begin
            r_sampled <= r_valid;
            r_samp_ch <= r_out_ch;
        end
    end

    assign w_err_inc = r_sampled & i_fr_error;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             r_sticky;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt    <= '0;
                    r_sticky <= 1'b0;
                end else if (i_cnt_clr && (i_cnt_sel == IDX_W'(gi))) begin
                    r_cnt    <= '0;
                    r_sticky <= 1'b0;
                end else if (w_err_inc && (r_samp_ch == IDX_W'(gi))) begin
                    r_sticky <= 1'b1;
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_cnt[gi]        = r_cnt;
            assign o_err_sticky[gi] = r_sticky;
        end
    endgenerate

    assign o_ready   = r_ready;
    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_fs      = r_fs;
    assign o_rs      = r_rs;
    assign o_mfas    = r_mfas;
    assign o_chk_rst = r_chk_rst;
    assign o_chid    = r_chid;
    assign o_err_cnt = w_cnt[i_cnt_sel];

endmodule

// File: tb/tb_odu_chk_sched.sv
// Randomized bench for odu_chk_sched: per-channel word sources, a burst-level
// schedule model and a frame-error counter model. Counter width is narrowed so
// saturation is reachable in a short run.
module tb_odu_chk_sched;

    localparam int NCH     = 4;
    localparam int BL      = 16;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int DEPTH   = 300;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    i_valid = '0;
    logic [NCH*384-1:0] i_data = '0;
    logic [NCH-1:0]    i_fs = '0;
    logic [NCH-1:0]    i_rs = '0;
    logic [NCH*8-1:0]  i_mfas = '0;
    logic [NCH-1:0]    o_ready;
    logic [383:0]      o_data;
    logic              o_valid;
    logic              o_fs;
    logic              o_rs;
    logic [7:0]        o_mfas;
    logic              o_chk_rst;
    logic              i_fr_error = 1'b0;
    logic [1:0]        o_chid;
    logic [1:0]        i_cnt_sel = '0;
    logic              i_cnt_clr = 1'b0;
    logic [CW-1:0]     o_err_cnt;
    logic [NCH-1:0]    o_err_sticky;

    odu_chk_sched #(.NUM_CH(NCH), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_data(i_data), .i_fs(i_fs), .i_rs(i_rs), .i_mfas(i_mfas),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_fs(o_fs), .o_rs(o_rs),
        .o_mfas(o_mfas), .o_chk_rst(o_chk_rst), .i_fr_error(i_fr_error), .o_chid(o_chid),
        .i_cnt_sel(i_cnt_sel), .i_cnt_clr(i_cnt_clr), .o_err_cnt(o_err_cnt),
        .o_err_sticky(o_err_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [383:0] wd_data [NCH][DEPTH];
    bit           wd_fs   [NCH][DEPTH];
    bit           wd_rs   [NCH][DEPTH];
    logic [7:0]   wd_mfas [NCH][DEPTH];
    int len [NCH];
    int pos [NCH];

    int exp_ch [$];
    int exp_pos [$];
    int exp_grant [$];
    int m_ptr;
    int m_cnt [NCH];
    bit m_sticky [NCH];
    int err_mode;
    bit clr_on_sample;

    task automatic load(input int ch, input int n);
        logic [383:0] w;
        len[ch] = n;
        pos[ch] = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 12; j++) w[j*32 +: 32] = $urandom;
            w[383:376] = 8'(ch);
            wd_data[ch][i] = w;
            wd_fs[ch][i]   = (i % 8 == 0);
            wd_rs[ch][i]   = 1'($urandom);
            wd_mfas[ch][i] = 8'($urandom);
        end
    endtask

    // Burst-level schedule: round robin over channels with words left, up to BL words each.
    task automatic build_model();
        int rem [NCH];
        int c, n;
        bit found;
        for (int k = 0; k < NCH; k++) rem[k] = len[k] - pos[k];
        forever begin
            found = 0;
            c = 0;
            for (int off = 1; off <= NCH; off++) begin
                if (!found && rem[(m_ptr + off) % NCH] > 0) begin
                    found = 1;
                    c = (m_ptr + off) % NCH;
                end
            end
            if (!found) break;
            m_ptr = c;
            exp_grant.push_back(c);
            n = (rem[c] < BL) ? rem[c] : BL;
            for (int i = 0; i < n; i++) begin
                exp_ch.push_back(c);
                exp_pos.push_back(len[c] - rem[c] + i);
            end
            rem[c] -= n;
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NCH; k++) begin
            if (pos[k] < len[k]) begin
                i_valid[k]           = 1'b1;
                i_data[k*384 +: 384] = wd_data[k][pos[k]];
                i_fs[k]              = wd_fs[k][pos[k]];
                i_rs[k]              = wd_rs[k][pos[k]];
                i_mfas[k*8 +: 8]     = wd_mfas[k][pos[k]];
            end else begin
                i_valid[k]           = 1'b0;
                i_data[k*384 +: 384] = '0;
                i_fs[k]              = 1'b0;
                i_rs[k]              = 1'b0;
                i_mfas[k*8 +: 8]     = '0;
            end
        end
    endtask

    // Error rule: in the cycle after a forwarded word, i_fr_error charges that word's channel.
    task automatic model_err(input bit v, input int ch);
        if (v && i_fr_error && !(i_cnt_clr && int'(i_cnt_sel) == ch)) begin
            if (m_cnt[ch] < CNT_MAX) m_cnt[ch]++;
            m_sticky[ch] = 1'b1;
        end
        if (i_cnt_clr) begin
            m_cnt[i_cnt_sel]    = 0;
            m_sticky[i_cnt_sel] = 1'b0;
        end
    endtask

    task automatic drive_err(input bit v, input int ch, input int p);
        case (err_mode)
            1:       i_fr_error = ($urandom_range(0, 2) == 0);
            2:       i_fr_error = v && ch == 1 && p >= 2 && p <= 4;
            3:       i_fr_error = v;
            default: i_fr_error = 1'b0;
        endcase
        i_cnt_clr = clr_on_sample && v;
        if (clr_on_sample) i_cnt_sel = 2'd1;
    endtask

    task automatic run_stream(input string name, input int stop_after);
        int cyc, beats, budget, c, p, cur_ch, cur_pos, last_ch, last_pos;
        bit cur_v, last_v;
        logic [NCH-1:0] fire;
        budget = 3 * exp_ch.size() + 8 * exp_grant.size() + 40;
        cyc = 0; beats = 0; last_v = 0; last_ch = 0; last_pos = 0;
        drive_inputs();
        while ((exp_ch.size() != 0 || exp_grant.size() != 0) && cyc < budget &&
               (stop_after < 0 || beats < stop_after)) begin
            @(negedge clk);
            model_err(last_v, last_ch);
            cur_v = 0; cur_ch = 0; cur_pos = 0;
            if (o_chk_rst) begin
                checks++;
                if (exp_grant.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_flush got chid %0d required no flush", name, o_chid);
                end else begin
                    c = exp_grant.pop_front();
                    if (o_chid !== 2'(c) || o_ready !== '0 || o_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s flush got chid %0d ready %b valid %b required chid %0d ready 0000 valid 0",
                                 name, o_chid, o_ready, o_valid, c);
                    end
                end
            end
            if (o_valid) begin
                checks++;
                if (exp_ch.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_word got chid %0d required no word", name, o_chid);
                end else begin
                    c = exp_ch.pop_front();
                    p = exp_pos.pop_front();
                    if ({o_data, o_fs, o_rs, o_mfas, o_chid} !==
                        {wd_data[c][p], wd_fs[c][p], wd_rs[c][p], wd_mfas[c][p], 2'(c)}) begin
                        errors++;
                        $display("FAIL %s word ch%0d pos%0d got chid %0d fs %b rs %b mfas %h data %h required fs %b rs %b mfas %h data %h",
                                 name, c, p, o_chid, o_fs, o_rs, o_mfas, o_data,
                                 wd_fs[c][p], wd_rs[c][p], wd_mfas[c][p], wd_data[c][p]);
                    end
                    beats++;
                    cur_v = 1; cur_ch = c; cur_pos = p;
                end
            end
            checks++;
            if (o_ready !== '0 && o_ready !== (4'b0001 << o_chid)) begin
                errors++;
                $display("FAIL %s ready_onehot got %b chid %0d required 0000 or one-hot of chid", name, o_ready, o_chid);
            end
            fire = i_valid & o_ready;
            last_v = cur_v; last_ch = cur_ch; last_pos = cur_pos;
            @(posedge clk); #1;
            for (int k = 0; k < NCH; k++) if (fire[k]) pos[k]++;
            drive_inputs();
            drive_err(last_v, last_ch, last_pos);
            cyc++;
        end
        if (cyc >= budget) begin
            checks++; errors++;
            $display("FAIL %s timeout got %0d words %0d grants outstanding required 0", name,
                     exp_ch.size(), exp_grant.size());
        end
        if (stop_after < 0) begin
            @(negedge clk);
            model_err(last_v, last_ch);
            checks++;
            if (o_valid !== 1'b0 || o_ready !== '0) begin
                errors++;
                $display("FAIL %s end_of_grant got valid %b ready %b required 0 0000", name, o_valid, o_ready);
            end
            @(posedge clk); #1;
            i_fr_error = 1'b0;
            i_cnt_clr  = 1'b0;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (o_valid !== 1'b0 || o_chk_rst !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_quiet got valid %b chk_rst %b required 0 0", name, o_valid, o_chk_rst);
                end
            end
        end
    endtask

    task automatic check_counters(input string name);
        for (int k = 0; k < NCH; k++) begin
            i_cnt_sel = 2'(k);
            #1;
            checks++;
            if (o_err_cnt !== CW'(m_cnt[k]) || o_err_sticky[k] !== m_sticky[k]) begin
                errors++;
                $display("FAIL %s counter ch%0d got cnt %0d sticky %b required cnt %0d sticky %b",
                         name, k, o_err_cnt, o_err_sticky[k], m_cnt[k], m_sticky[k]);
            end
        end
        i_cnt_sel = 2'd0;
    endtask

    task automatic clear_counters();
        for (int k = 0; k < NCH; k++) begin
            @(posedge clk); #1;
            i_cnt_clr = 1'b1;
            i_cnt_sel = 2'(k);
            @(posedge clk); #1;
            i_cnt_clr = 1'b0;
            m_cnt[k] = 0;
            m_sticky[k] = 1'b0;
        end
        i_cnt_sel = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            len[k] = 0; pos[k] = 0; m_cnt[k] = 0; m_sticky[k] = 1'b0;
        end
        drive_inputs();
        i_fr_error = 1'b0; i_cnt_clr = 1'b0; i_cnt_sel = '0;
        err_mode = 0; clr_on_sample = 0;
        exp_ch.delete(); exp_pos.delete(); exp_grant.delete();
        m_ptr = NCH - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (o_ready !== '0 || o_valid !== 1'b0 || o_fs !== 1'b0 || o_rs !== 1'b0 ||
            o_data !== '0 || o_mfas !== '0 || o_chk_rst !== 1'b0 || o_chid !== '0 ||
            o_err_sticky !== '0 || o_err_cnt !== '0) begin
            errors++;
            $display("FAIL %s zero_state got ready %b valid %b fs %b rs %b mfas %h chk_rst %b chid %0d sticky %b cnt %0d data_nonzero %b required all 0",
                     name, o_ready, o_valid, o_fs, o_rs, o_mfas, o_chk_rst, o_chid,
                     o_err_sticky, o_err_cnt, |o_data);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        checks++;
        if (o_chk_rst !== 1'b0 || o_ready !== '0) begin
            errors++;
            $display("FAIL reset idle_no_request got chk_rst %b ready %b required 0 0000", o_chk_rst, o_ready);
        end
    endtask

    task automatic test_single_ch();
        do_reset();
        load(0, 20);
        build_model();
        run_stream("single_ch", -1);
        check_counters("single_ch");
    endtask

    task automatic test_all_ch();
        do_reset();
        load(0, 32);
        for (int k = 1; k < NCH; k++) load(k, 16);
        build_model();
        run_stream("all_ch", -1);
    endtask

    task automatic test_short_burst();
        do_reset();
        load(2, 5);
        build_model();
        run_stream("short_burst", -1);
    endtask

    task automatic test_err_window();
        do_reset();
        for (int k = 0; k < NCH; k++) load(k, 16);
        err_mode = 2;
        build_model();
        run_stream("err_window", -1);
        check_counters("err_window");
        err_mode = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        err_mode = 3;
        load(1, CNT_MAX - 1);
        build_model();
        run_stream("sat_fill", -1);
        check_counters("sat_fill");
        load(1, 3);
        build_model();
        run_stream("sat_top", -1);
        check_counters("sat_top");
        clr_on_sample = 1;
        load(1, 1);
        build_model();
        run_stream("sat_clear_wins", -1);
        clr_on_sample = 0;
        err_mode = 0;
        check_counters("sat_clear_wins");
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < NCH; k++) load(k, $urandom_range(0, 40));
            err_mode = 1;
            build_model();
            run_stream("random", -1);
            err_mode = 0;
            check_counters("random");
            clear_counters();
            check_counters("random_clear");
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load(3, 20);
        build_model();
        run_stream("mid_burst", 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_burst_reset");
        for (int k = 0; k < NCH; k++) begin
            len[k] = 0; pos[k] = 0; m_cnt[k] = 0; m_sticky[k] = 1'b0;
        end
        drive_inputs();
        exp_ch.delete(); exp_pos.delete(); exp_grant.delete();
        m_ptr = NCH - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_burst residual_word got valid %b required 0", o_valid);
            end
        end
        @(posedge clk); #1;
        load(0, 10);
        load(3, 10);
        build_model();
        run_stream("after_reset", -1);
    endtask

    initial begin
        test_reset();
        test_single_ch();
        test_all_ch();
        test_short_burst();
        test_err_window();
        test_saturation();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
